// File: rtl/seg_sequence_monitor.sv
// Seven-segment receive checker: glitch-filters seg_in, decodes to BCD and tracks the 0..9 count.
// Optional saturating error counter enabled by defining SEG_SEQ_MON_ERR_CNT_EN.
//
// state  | meaning
// SEARCH | not locked; waiting for any legal digit to start tracking
// TRACK  | locked; each accepted digit is compared against expected_q
module seg_sequence_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           seg_in,
  output logic [3:0]           digit,
  output logic                 digit_valid,
  output logic                 locked,
  output logic                 seq_err,
  output logic                 bad_pattern,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic {SEARCH, TRACK} state_t;

  localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);

  state_t     state_q, state_d;
  logic [6:0] seg_q, seg_d;
  logic [6:0] last_pat_q, last_pat_d;
  logic [7:0] run_q, run_d;
  logic [3:0] digit_q, digit_d;
  logic [3:0] expected_q, expected_d;
  logic       digit_valid_q, digit_valid_d;
  logic       seq_err_q, seq_err_d;
  logic       bad_pattern_q, bad_pattern_d;
  logic       accept;
  logic       dec_legal;
  logic [3:0] dec_digit;
  logic [3:0] dec_next;

  always_comb begin
    dec_digit = 4'd0;
    dec_legal = 1'b1;
    case (seg_in)
      7'b1111110: dec_digit = 4'd0;
      7'b0110000: dec_digit = 4'd1;
      7'b1101101: dec_digit = 4'd2;
      7'b1111001: dec_digit = 4'd3;
      7'b0110011: dec_digit = 4'd4;
      7'b1011011: dec_digit = 4'd5;
      7'b1011111: dec_digit = 4'd6;
      7'b1110000: dec_digit = 4'd7;
      7'b1111111: dec_digit = 4'd8;
      7'b1111011: dec_digit = 4'd9;
      default:    dec_legal = 1'b0;
    endcase
    dec_next = (dec_digit == 4'd9) ? 4'd0 : dec_digit + 4'd1;
  end

  always_comb begin
    seg_d         = seg_in;
    run_d         = (seg_in != seg_q) ? 8'd1 :
                    (run_q == RUN_MAX) ? run_q : run_q + 8'd1;
    // last_pat gates acceptance so a saturated run fires only once per pattern
    accept        = (run_d == RUN_MAX) && (seg_in != last_pat_q);
    state_d       = state_q;
    last_pat_d    = last_pat_q;
    digit_d       = digit_q;
    expected_d    = expected_q;
    digit_valid_d = 1'b0;
    seq_err_d     = 1'b0;
    bad_pattern_d = 1'b0;
    if (accept) begin
      last_pat_d = seg_in;
      if (!dec_legal) begin
        bad_pattern_d = 1'b1;
        state_d       = SEARCH;
      end else begin
        digit_valid_d = 1'b1;
        digit_d       = dec_digit;
        expected_d    = dec_next;
        seq_err_d     = (state_q == TRACK) && (dec_digit != expected_q);
        state_d       = TRACK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SEARCH;
      seg_q         <= 7'd0;
      last_pat_q    <= 7'd0;
      run_q         <= 8'd1;
      digit_q       <= 4'd0;
      expected_q    <= 4'd0;
      digit_valid_q <= 1'b0;
      seq_err_q     <= 1'b0;
      bad_pattern_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      seg_q         <= seg_d;
      last_pat_q    <= last_pat_d;
      run_q         <= run_d;
      digit_q       <= digit_d;
      expected_q    <= expected_d;
      digit_valid_q <= digit_valid_d;
      seq_err_q     <= seq_err_d;
      bad_pattern_q <= bad_pattern_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign locked      = (state_q == TRACK);
  assign seq_err     = seq_err_q;
  assign bad_pattern = bad_pattern_q;

`ifdef SEG_SEQ_MON_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((seq_err_d || bad_pattern_d) && (err_q != '1)) err_d = err_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_seg_sequence_monitor.sv
// Directed bench: main instance (STABLE_CYCLES=4) plus a STABLE_CYCLES=1, 2-bit counter instance.
module tb_seg_sequence_monitor;

`ifdef SEG_SEQ_MON_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_a = 7'd0;
  logic [6:0] seg_b = 7'd0;

  logic [3:0] digit_a, digit_b;
  logic       valid_a, valid_b, locked_a, locked_b;
  logic       serr_a, serr_b, bad_a, bad_b;
  logic [7:0] err_a;
  logic [1:0] err_b;

  always #5 clk = ~clk;

  seg_sequence_monitor #(.STABLE_CYCLES(4), .ERR_CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_a), .digit(digit_a), .digit_valid(valid_a),
    .locked(locked_a), .seq_err(serr_a), .bad_pattern(bad_a), .err_count(err_a));

  seg_sequence_monitor #(.STABLE_CYCLES(1), .ERR_CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_b), .digit(digit_b), .digit_valid(valid_b),
    .locked(locked_b), .seq_err(serr_b), .bad_pattern(bad_b), .err_count(err_b));

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid, n_seq, n_bad, n_both, vld_idx;
  int nb_valid = 0, nb_seq = 0;
  logic [3:0] dq[$];
  logic [6:0] pat [10];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int exp_err(input int n, input int maxv);
    if (!ERR_EN) return 0;
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic clear_counts();
    n_valid = 0; n_seq = 0; n_bad = 0; vld_idx = -1;
    dq.delete();
  endtask

  // Called just after a falling edge; drives p across n rising edges, sampling at each falling edge.
  task automatic hold_a(input logic [6:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      seg_a = p;
      @(negedge clk);
      if (valid_a) begin n_valid++; vld_idx = i; dq.push_back(digit_a); end
      if (serr_a) n_seq++;
      if (bad_a) n_bad++;
      if (serr_a && bad_a) n_both++;
    end
  endtask

  task automatic hold_b(input logic [6:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      seg_b = p;
      @(negedge clk);
      if (valid_b) nb_valid++;
      if (serr_b) nb_seq++;
    end
  endtask

  initial begin
    pat[0] = 7'b1111110; pat[1] = 7'b0110000; pat[2] = 7'b1101101; pat[3] = 7'b1111001;
    pat[4] = 7'b0110011; pat[5] = 7'b1011011; pat[6] = 7'b1011111; pat[7] = 7'b1110000;
    pat[8] = 7'b1111111; pat[9] = 7'b1111011;
    n_both = 0;
    clear_counts();

    @(negedge clk); @(negedge clk);
    check("rst_digit", digit_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_locked", locked_a, 0);
    check("rst_seq_err", serr_a, 0);
    check("rst_bad", bad_a, 0);
    check("rst_err", err_a, 0);
    rst_n = 1'b1;

    hold_a(7'd0, 6);
    check("blank_no_bad", n_bad, 0);
    check("blank_unlocked", locked_a, 0);

    hold_a(pat[0], 6);
    check("pre_rst_locked", locked_a, 1);
    hold_a(pat[1], 2);
    #2 rst_n = 1'b0; seg_a = 7'd0;
    #1;
    check("async_digit", digit_a, 0);
    check("async_valid", valid_a, 0);
    check("async_locked", locked_a, 0);
    check("async_seq_err", serr_a, 0);
    check("async_bad", bad_a, 0);
    check("async_err", err_a, 0);
    @(negedge clk); rst_n = 1'b1;

    clear_counts();
    hold_a(pat[5], 4);
    check("post_rst_valid", n_valid, 1);
    check("post_rst_digit", digit_a, 5);
    check("post_rst_locked", locked_a, 1);

    rst_n = 1'b0; seg_a = 7'd0;
    @(negedge clk); rst_n = 1'b1;
    clear_counts();
    hold_a(pat[0], 10);
    check("seq_first_latency", vld_idx, 3);
    for (int d = 1; d < 10; d++) hold_a(pat[d], 10);
    hold_a(pat[0], 10);
    check("seq_valid_cnt", n_valid, 11);
    for (int i = 0; i < 11 && i < dq.size(); i++) check($sformatf("seq_digit%0d", i), dq[i], i % 10);
    check("seq_no_err", n_seq, 0);
    check("seq_err_cnt", err_a, 0);

    hold_a(pat[1], 10); hold_a(pat[2], 10); hold_a(pat[3], 10);
    clear_counts();
    hold_a(pat[5], 2);
    hold_a(pat[3], 10);
    check("glitch_no_valid", n_valid, 0);
    check("glitch_no_seq", n_seq, 0);
    check("glitch_digit", digit_a, 3);

    hold_a(pat[4], 10);
    clear_counts();
    hold_a(pat[6], 10);
    check("skip_valid", n_valid, 1);
    check("skip_digit", digit_a, 6);
    check("skip_seq_err", n_seq, 1);
    check("skip_err_cnt", err_a, exp_err(1, 255));
    clear_counts();
    hold_a(pat[7], 10);
    check("after_skip_valid", n_valid, 1);
    check("after_skip_no_seq", n_seq, 0);

    clear_counts();
    hold_a(7'b1010101, 4);
    check("illegal_bad", n_bad, 1);
    check("illegal_unlocked", locked_a, 0);
    check("illegal_err_cnt", err_a, exp_err(2, 255));
    check("illegal_digit_hold", digit_a, 7);
    check("illegal_no_valid", n_valid, 0);
    clear_counts();
    hold_a(pat[2], 10);
    check("relock_valid", n_valid, 1);
    check("relock_locked", locked_a, 1);
    check("relock_no_seq", n_seq, 0);
    check("relock_digit", digit_a, 2);
    check("never_both", n_both, 0);

    hold_b(pat[0], 1);
    check("b_one_cycle_valid", nb_valid, 1);
    check("b_locked", locked_b, 1);
    hold_b(pat[2], 1); hold_b(pat[4], 1);
    check("b_err_two", err_b, exp_err(2, 3));
    hold_b(pat[6], 1); hold_b(pat[8], 1); hold_b(pat[0], 1);
    check("b_seq_errs", nb_seq, 5);
    check("b_err_sat", err_b, exp_err(5, 3));
    hold_b(pat[0], 5);
    check("b_err_held", err_b, exp_err(5, 3));
    check("b_valid_cnt", nb_valid, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_sequence_monitor.md
# seg_sequence_monitor

- Receive side of the seven-segment digit path: samples a 7-bit segment bus, filters glitches, and decodes stable patterns back to BCD digits 0–9.
- Checks that consecutive digits follow the 0→9→0 counting sequence.
- Reports decoded digits, sequence breaks and illegal patterns.
- Used as an on-chip loopback checker on the segment outputs of the digit-counter display path. Runs entirely in the system clock domain.

## Interface

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted; legal range 1–255.
- ERR_CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; deassertion synchronous to clk externally.
- seg_in  input  7  segment pattern, active-high, bit6=a … bit0=g; synchronous to clk.
- digit  output  4  last accepted legal digit.
- digit_valid  output  1  one-cycle pulse when digit is updated.
- locked  output  1  high while tracking a sequence.
- seq_err  output  1  one-cycle pulse when an accepted digit breaks the sequence.
- bad_pattern  output  1  one-cycle pulse when an illegal pattern is accepted.
- err_count  output  ERR_CNT_W  saturating error count; see Configuration.

## Operation

- Legal patterns (a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Every other value, including blank 0000000, is illegal.
- Stability filter:
  - Internal sample register seg_q <= seg_in every edge.
  - Run counter resets to 1 when seg_in != seg_q; otherwise increments, saturating at STABLE_CYCLES.
- Acceptance: occurs on the edge where the run reaches STABLE_CYCLES and the pattern differs from last_pat. last_pat <= pattern on acceptance.
  - Exactly one acceptance per distinct stable pattern.
  - Glitches shorter than STABLE_CYCLES that return to last_pat produce nothing.
- FSM states:
  - SEARCH (locked=0):
    - Accepted legal digit d: digit<=d, digit_valid pulse, expected<=(d+1) mod 10, go to TRACK.
    - Accepted illegal pattern: bad_pattern pulse, stay in SEARCH.
  - TRACK (locked=1):
    - Accepted legal d == expected: digit_valid pulse, expected advances.
    - Accepted legal d != expected: digit_valid and seq_err pulse on the same cycle; digit<=d, expected<=(d+1) mod 10 (resync); stay in TRACK.
    - Accepted illegal pattern: bad_pattern pulse, go to SEARCH; digit holds.
- Wrap: after 9 the expected digit is 0. 9→0 is not an error.
- Simultaneous events: only one acceptance per edge, so seq_err and bad_pattern are never high together.
- Reset values:
  - digit=0, digit_valid=0, locked=0, seq_err=0, bad_pattern=0, err_count=0.
  - FSM=SEARCH, last_pat=0000000, seg_q=0000000, run=1.
  - Because last_pat resets to blank, a blank bus after reset is never flagged.
- Reset mid-operation: all outputs and state return to reset values immediately. Any pattern in progress is discarded.

## Timing

- Pattern P first sampled at edge k and held: accepted at edge k+STABLE_CYCLES-1. Outputs are registered and visible after that edge.
- With STABLE_CYCLES=1, acceptance happens on the first sampling edge.
- digit_valid, seq_err and bad_pattern are high for exactly one clk cycle per acceptance.
- locked changes on the same edge as the acceptance that causes the transition.
- err_count updates on the same edge as the seq_err or bad_pattern pulse.

## Configuration

- SEG_SEQ_MON_ERR_CNT_EN defined:
  - err_count increments by 1 on every seq_err or bad_pattern pulse.
  - Saturates at all-ones; cleared only by reset.
- Not defined:
  - Counter logic is compiled out and err_count is constant 0.
  - The port remains present.

## Test plan

- Reset: drive digits to lock, then pulse rst_n low mid-pattern → all outputs 0 asynchronously, before the next edge. After release, first legal digit 5 (1011011) held 4 cycles → digit_valid, digit=5, locked=1.
- Full sequence, STABLE_CYCLES=4: patterns 0..9,0 each held 10 cycles → 11 digit_valid pulses, digits 0,1,…,9,0, first pulse 3 edges after first sample of 0, no seq_err, err_count=0.
- Glitch filter: hold 3 (1111001) until accepted, inject 5 for 2 cycles, return to 3 → no digit_valid, no seq_err, digit stays 3.
- Skip: accepted 4 then 6 → digit_valid with digit=6 and one seq_err pulse, err_count=1. Then 7 → digit_valid, no seq_err.
- Illegal pattern in TRACK: 1010101 held 4 cycles → one bad_pattern pulse, locked=0, err_count +1. Then 2 → digit_valid, locked=1, no seq_err.
- Saturation, ERR_CNT_W=2, macro defined: 5 consecutive skip errors → err_count=3, held. Repeat without the macro → err_count=0 throughout.
